line_card_egress_fifo_writer: RTL and testbench

//  Egress half of the line-card buffer: accepts the 64-bit crossbar stream (TDEST={bcast, global dest port},

---
 rtl/line_card_egress_fifo_writer_pkg.sv | 50 +++++
 rtl/line_card_egress_fifo_writer_if.sv | 25 ++
 rtl/line_card_egress_fifo_writer_bcast_occupancy.sv | 44 ++++
 rtl/line_card_egress_fifo_writer.sv | 173 +++++++++++++++++
 tb/tb_line_card_egress_fifo_writer.sv | 330 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/line_card_egress_fifo_writer_pkg.sv
`default_nettype none
// ============================================================================
// Module : egress_buffer_pkg
// Brief  : Shared types, header layout and helpers for the egress FIFO writer.
// Rev    : 1.0
// ============================================================================
package egress_buffer_pkg;

    localparam int EGRESS_WORD_W     = 72;
    localparam int EGRESS_HDR_LEN_W  = 16;
    localparam int EGRESS_HDR_VLAN_W = 12;
    localparam int HDR_LEN_LSB       = 0;
    localparam int HDR_VLAN_LSB      = HDR_LEN_LSB + EGRESS_HDR_LEN_W;
    // Region index holds up to 31 local ports plus the broadcast region.
    localparam int REGION_IDX_W      = 5;

    typedef logic [EGRESS_HDR_VLAN_W-1:0] vlan_t;
    typedef logic [REGION_IDX_W-1:0]      region_idx_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        DROP   = 2'd2,
        HEADER = 2'd3
    } wr_state_t;

    function automatic logic [3:0] popcount8(input logic [7:0] keep);
        logic [3:0] cnt;
        cnt = '0;
        for (int i = 0; i < 8; i++) begin
            cnt = cnt + {3'b000, keep[i]};
        end
        return cnt;
    endfunction

    function automatic logic [EGRESS_WORD_W-1:0] make_header(input vlan_t vlan,
                                                           input logic [EGRESS_HDR_LEN_W-1:0] len);
        logic [EGRESS_WORD_W-1:0] hdr;
        hdr = '0;
        hdr[HDR_LEN_LSB  +: EGRESS_HDR_LEN_W]  = len;
        hdr[HDR_VLAN_LSB +: EGRESS_HDR_VLAN_W] = vlan;
        return hdr;
    endfunction

    function automatic logic [31:0] sat_inc32(input logic [31:0] value);
        return (value == 32'hFFFF_FFFF) ? value : value + 32'd1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/line_card_egress_fifo_writer_if.sv
`default_nettype none
// ============================================================================
// Module : AXIStream
// Brief  : AXI4-Stream bundle carrying crossbar traffic into the egress writer.
// Rev    : 1.0
// ============================================================================
interface AXIStream #(
    parameter int DATA_W = 64,
    parameter int DEST_W = 7,
    parameter int USER_W = 12
) ();
    logic [DATA_W-1:0]   tdata;
    logic [DATA_W/8-1:0] tkeep;
    logic                tvalid;
    logic                tready;
    logic                tlast;
    logic [DEST_W-1:0]   tdest;
    logic [USER_W-1:0]   tuser;
    logic                areset_n;

    modport master   (output tdata, tkeep, tvalid, tlast, tdest, tuser, areset_n, input tready);
    modport slave    (input tdata, tkeep, tvalid, tlast, tdest, tuser, areset_n, output tready);
    modport receiver (input tdata, tkeep, tvalid, tlast, tdest, tuser, areset_n, output tready);
endinterface
`default_nettype wire

// File: rtl/line_card_egress_fifo_writer_bcast_occupancy.sv
`default_nettype none
// ============================================================================
// Module : egress_bcast_occupancy
// Brief  : Registers the read pointer of the slowest broadcast reader.
// Rev    : 1.0
// ============================================================================
module egress_bcast_occupancy #(
    parameter int LOCAL_PORTS = 24,
    parameter int PTR_BITS    = 12
) (
    input  wire logic                clk,
    input  wire logic                areset,
    input  wire logic [PTR_BITS:0]   committed,
    input  wire logic [PTR_BITS:0]   bcast_rd_ptr [LOCAL_PORTS],
    output logic      [PTR_BITS:0]   slow_rd
);

    logic [PTR_BITS:0] best_occ;
    logic [PTR_BITS:0] best_rd;

    // Largest committed-minus-read distance marks the reader furthest behind.
    always_comb begin
        logic [PTR_BITS:0] occ;
        best_rd  = bcast_rd_ptr[0];
        best_occ = committed - bcast_rd_ptr[0];
        for (int i = 1; i < LOCAL_PORTS; i++) begin
            occ = committed - bcast_rd_ptr[i];
            if (occ > best_occ) begin
                best_occ = occ;
                best_rd  = bcast_rd_ptr[i];
            end
        end
    end

    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            slow_rd <= '0;
        end else begin
            slow_rd <= best_rd;
        end
    end

endmodule
`default_nettype wire

// File: rtl/line_card_egress_fifo_writer.sv
`default_nettype none
// ============================================================================
// Module : line_card_egress_fifo_writer
// Brief  : Writes whole crossbar frames into per-port circular URAM regions.
// Rev    : 1.0
// ============================================================================
module line_card_egress_fifo_writer
    import egress_buffer_pkg::*;
#(
    parameter int BASE_PORT       = 0,
    parameter int NUM_PORTS       = 50,
    parameter int LOCAL_PORTS     = 24,
    parameter int REGION_DEPTH    = 4096,
    parameter int MAX_FRAME_WORDS = 191,
    parameter int PORT_BITS       = $clog2(NUM_PORTS),
    parameter int PTR_BITS        = $clog2(REGION_DEPTH),
    parameter int REGION_BITS     = REGION_IDX_W
) (
    input  wire logic                          clk,
    input  wire logic                          areset,
    AXIStream.receiver                         axi_rx,
    output logic                               wr_en,
    output logic [REGION_BITS+PTR_BITS-1:0]    wr_addr,
    output logic [EGRESS_WORD_W-1:0]           wr_data,
    output logic [PTR_BITS:0]                  wr_ptr_committed [LOCAL_PORTS+1],
    input  wire logic [PTR_BITS:0]             rd_ptr [LOCAL_PORTS],
    input  wire logic [PTR_BITS:0]             bcast_rd_ptr [LOCAL_PORTS],
    output logic [31:0]                        drop_count
);

    localparam int WCNT_BITS = $clog2(MAX_FRAME_WORDS + 1);
    localparam logic [WCNT_BITS-1:0] MAX_WORDS = WCNT_BITS'(MAX_FRAME_WORDS);
    // Admit only if the worst-case frame (header + MAX_FRAME_WORDS) still fits.
    localparam logic [PTR_BITS:0] OCC_LIMIT = (PTR_BITS+1)'(REGION_DEPTH - MAX_FRAME_WORDS - 1);

    wr_state_t                 state;
    region_idx_t               region;
    logic [PTR_BITS:0]         start_ptr;
    logic [PTR_BITS:0]         next_ptr;
    logic [WCNT_BITS-1:0]      words;
    logic [EGRESS_HDR_LEN_W-1:0] len_bytes;
    vlan_t                     vlan;

    logic [PTR_BITS:0]         bcast_slow_rd;
    logic                      beat;
    logic                      region_ok;
    region_idx_t               region_sel;
    logic [PTR_BITS:0]         sel_rd;
    logic [PTR_BITS:0]         committed_sel;
    logic [PTR_BITS:0]         first_ptr;
    logic [PTR_BITS:0]         occ;
    logic                      admit;
    logic [3:0]                beat_bytes;
    int                        rel;
    logic                      unused_areset_n;

    assign unused_areset_n = axi_rx.areset_n;
    assign beat            = axi_rx.tvalid && axi_rx.tready;
    assign beat_bytes      = popcount8(axi_rx.tkeep);

    egress_bcast_occupancy #(
        .LOCAL_PORTS (LOCAL_PORTS),
        .PTR_BITS    (PTR_BITS)
    ) u_bcast_occ (
        .clk          (clk),
        .areset       (areset),
        .committed    (wr_ptr_committed[LOCAL_PORTS]),
        .bcast_rd_ptr (bcast_rd_ptr),
        .slow_rd      (bcast_slow_rd)
    );

    always_comb begin
        rel        = int'(axi_rx.tdest[PORT_BITS-1:0]) - BASE_PORT;
        region_ok  = 1'b0;
        region_sel = '0;
        sel_rd     = '0;
        if (axi_rx.tdest[PORT_BITS]) begin
            region_ok  = 1'b1;
            region_sel = region_idx_t'(LOCAL_PORTS);
            sel_rd     = bcast_slow_rd;
        end else if (rel >= 0 && rel < LOCAL_PORTS) begin
            region_ok  = 1'b1;
            region_sel = region_idx_t'(rel);
            sel_rd     = rd_ptr[region_sel];
        end
        committed_sel = wr_ptr_committed[region_sel];
        first_ptr     = committed_sel + 1'b1;
        occ           = committed_sel - sel_rd;
        admit         = region_ok && (occ <= OCC_LIMIT);
    end

    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            state         <= IDLE;
            wr_en         <= 1'b0;
            wr_addr       <= '0;
            wr_data       <= '0;
            axi_rx.tready <= 1'b0;
            drop_count    <= '0;
            region        <= '0;
            start_ptr     <= '0;
            next_ptr      <= '0;
            words         <= '0;
            len_bytes     <= '0;
            vlan          <= '0;
            for (int i = 0; i < LOCAL_PORTS + 1; i++) begin
                wr_ptr_committed[i] <= '0;
            end
        end else begin
            wr_en         <= 1'b0;
            axi_rx.tready <= 1'b1;
            case (state)
                IDLE: begin
                    if (beat) begin
                        if (!admit) begin
                            drop_count <= sat_inc32(drop_count);
                            if (!axi_rx.tlast) state <= DROP;
                        end else begin
                            region    <= region_sel;
                            start_ptr <= committed_sel;
                            next_ptr  <= first_ptr + 1'b1;
                            wr_en     <= 1'b1;
                            wr_addr   <= {region_sel, first_ptr[PTR_BITS-1:0]};
                            wr_data   <= {axi_rx.tkeep, axi_rx.tdata};
                            words     <= WCNT_BITS'(1);
                            len_bytes <= {12'h000, beat_bytes};
                            vlan      <= axi_rx.tuser;
                            if (axi_rx.tlast) begin
                                state         <= HEADER;
                                axi_rx.tready <= 1'b0;
                            end else begin
                                state <= DATA;
                            end
                        end
                    end
                end
                DATA: begin
                    if (beat) begin
                        if (words == MAX_WORDS) begin
                            drop_count <= sat_inc32(drop_count);
                            state      <= axi_rx.tlast ? IDLE : DROP;
                        end else begin
                            wr_en     <= 1'b1;
                            wr_addr   <= {region, next_ptr[PTR_BITS-1:0]};
                            wr_data   <= {axi_rx.tkeep, axi_rx.tdata};
                            next_ptr  <= next_ptr + 1'b1;
                            words     <= words + 1'b1;
                            len_bytes <= len_bytes + {12'h000, beat_bytes};
                            if (axi_rx.tlast) begin
                                state         <= HEADER;
                                axi_rx.tready <= 1'b0;
                            end
                        end
                    end
                end
                DROP: begin
                    if (beat && axi_rx.tlast) state <= IDLE;
                end
                HEADER: begin
                    // Header lands last so readers never see a partial frame.
                    wr_en                    <= 1'b1;
                    wr_addr                  <= {region, start_ptr[PTR_BITS-1:0]};
                    wr_data                  <= make_header(vlan, len_bytes);
                    wr_ptr_committed[region] <= next_ptr;
                    state                    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_line_card_egress_fifo_writer.sv
`default_nettype none
// ============================================================================
// Module : tb_line_card_egress_fifo_writer
// Brief  : Directed self-checking bench for the egress FIFO writer.
// Rev    : 1.0
// ============================================================================
module tb_line_card_egress_fifo_writer;
    import egress_buffer_pkg::*;

    localparam int LP = 24;

    logic        clk = 1'b0;
    logic        areset;
    logic        wr_en;
    logic [16:0] wr_addr;
    logic [71:0] wr_data;
    logic [12:0] committed    [LP+1];
    logic [12:0] rd_ptr       [LP];
    logic [12:0] bcast_rd_ptr [LP];
    logic [31:0] drop_count;

    int compared   = 0;
    int mismatched = 0;
    int stalls     = 0;
    logic [88:0] wlog [$];

    always #5 clk = ~clk;

    AXIStream #(.DATA_W(64), .DEST_W(7), .USER_W(12)) axi_rx ();

    line_card_egress_fifo_writer dut (
        .clk              (clk),
        .areset           (areset),
        .axi_rx           (axi_rx),
        .wr_en            (wr_en),
        .wr_addr          (wr_addr),
        .wr_data          (wr_data),
        .wr_ptr_committed (committed),
        .rd_ptr           (rd_ptr),
        .bcast_rd_ptr     (bcast_rd_ptr),
        .drop_count       (drop_count)
    );

    always @(negedge clk) begin
        if (wr_en === 1'b1) wlog.push_back({wr_addr, wr_data});
    end

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_beat(input logic [63:0] d, input logic [7:0] k, input logic last,
                             input logic [6:0] dest, input logic [11:0] user);
        int n;
        axi_rx.tvalid = 1'b1;
        axi_rx.tdata  = d;
        axi_rx.tkeep  = k;
        axi_rx.tlast  = last;
        axi_rx.tdest  = dest;
        axi_rx.tuser  = user;
        n = 0;
        @(negedge clk);
        while (axi_rx.tready !== 1'b1 && n < 20) begin
            n++;
            stalls++;
            @(negedge clk);
        end
        if (n >= 20) begin
            compared++;
            mismatched++;
            $display("FAIL beat_timeout: tready=%b after %0d cycles, required 1", axi_rx.tready, n);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [6:0] dest, input logic [11:0] vlan, input int nbytes,
                              input logic [63:0] seed, input bit gaps);
        int nw;
        int rem;
        logic [7:0] keep;
        nw  = (nbytes + 7) / 8;
        rem = nbytes % 8;
        for (int i = 0; i < nw; i++) begin
            keep = (i == nw - 1 && rem != 0) ? (8'hFF >> (8 - rem)) : 8'hFF;
            send_beat(seed + 64'(i), keep, (i == nw - 1), dest, vlan);
            if (gaps && (i % 2 == 0) && i < nw - 1) begin
                axi_rx.tvalid = 1'b0;
                wait_cycles(1);
            end
        end
        axi_rx.tvalid = 1'b0;
        axi_rx.tlast  = 1'b0;
    endtask

    // Checks a 64-byte frame's write sequence: 8 data words then header.
    task automatic check_frame64(input string name, input int region, input int s,
                                 input logic [63:0] seed, input logic [11:0] vlan);
        logic [16:0] ea;
        logic [71:0] ed;
        compared++;
        if (wlog.size() !== 9) begin
            mismatched++;
            $display("FAIL %s_write_count: got %0d writes, required 9", name, wlog.size());
        end else begin
            for (int i = 0; i < 9; i++) begin
                if (i < 8) begin
                    ea = {5'(region), 12'((s + 1 + i) % 4096)};
                    ed = {8'hFF, seed + 64'(i)};
                end else begin
                    ea = {5'(region), 12'(s % 4096)};
                    ed = {44'h0, vlan, 16'd64};
                end
                compared++;
                if (wlog[i] !== {ea, ed}) begin
                    mismatched++;
                    $display("FAIL %s_write%0d: got addr=%h data=%h, required addr=%h data=%h",
                             name, i, wlog[i][88:72], wlog[i][71:0], ea, ed);
                end
            end
        end
    endtask

    task automatic test_reset;
        bit any_nz;
        any_nz = 1'b0;
        for (int i = 0; i < LP + 1; i++) if (committed[i] !== 13'd0) any_nz = 1'b1;
        compared++;
        if ({wr_en, wr_addr, wr_data, drop_count, axi_rx.tready, any_nz} !== '0) begin
            mismatched++;
            $display("FAIL reset_outputs: wr_en=%b addr=%h data=%h drops=%0d tready=%b ptr_nz=%b, required all 0",
                     wr_en, wr_addr, wr_data, drop_count, axi_rx.tready, any_nz);
        end
        areset = 1'b0;
        wait_cycles(1);
        compared++;
        if (axi_rx.tready !== 1'b1) begin
            mismatched++;
            $display("FAIL reset_release_tready: got %b, required 1", axi_rx.tready);
        end
    endtask

    task automatic test_unicast_64b;
        wlog.delete();
        send_frame(7'd3, 12'd5, 64, 64'h1000, 1'b0);
        compared++;
        if (committed[3] !== 13'd0) begin
            mismatched++;
            $display("FAIL uni64_commit_early: got %0d, required 0", committed[3]);
        end
        wait_cycles(1);
        compared++;
        if (committed[3] !== 13'd9) begin
            mismatched++;
            $display("FAIL uni64_commit: got %0d, required 9", committed[3]);
        end
        wait_cycles(1);
        check_frame64("uni64", 3, 0, 64'h1000, 12'd5);
    endtask

    task automatic test_short_frame;
        wlog.delete();
        send_frame(7'd3, 12'd7, 61, 64'h2000, 1'b0);
        wait_cycles(3);
        compared++;
        if (wlog.size() !== 9) begin
            mismatched++;
            $display("FAIL short_write_count: got %0d, required 9", wlog.size());
        end else begin
            compared++;
            if (wlog[7] !== {5'd3, 12'd17, 8'h1F, 64'h2007}) begin
                mismatched++;
                $display("FAIL short_last_data: got %h, required %h", wlog[7], {5'd3, 12'd17, 8'h1F, 64'h2007});
            end
            compared++;
            if (wlog[8] !== {5'd3, 12'd9, 44'h0, 12'd7, 16'd61}) begin
                mismatched++;
                $display("FAIL short_header: got %h, required %h", wlog[8], {5'd3, 12'd9, 44'h0, 12'd7, 16'd61});
            end
        end
        compared++;
        if (committed[3] !== 13'd18) begin
            mismatched++;
            $display("FAIL short_commit: got %0d, required 18", committed[3]);
        end
    endtask

    task automatic test_bcast_full;
        bcast_rd_ptr[7] = 13'd4287;
        wait_cycles(3);
        wlog.delete();
        send_frame(7'h40, 12'd2, 64, 64'h4000, 1'b0);
        wait_cycles(3);
        compared++;
        if (drop_count !== 32'd1 || wlog.size() !== 0 || committed[LP] !== 13'd0) begin
            mismatched++;
            $display("FAIL bcast_full_drop: drops=%0d writes=%0d commit=%0d, required 1/0/0",
                     drop_count, wlog.size(), committed[LP]);
        end
        bcast_rd_ptr[7] = 13'd4288;
        wait_cycles(3);
        send_frame(7'h40, 12'd2, 64, 64'h4100, 1'b0);
        wait_cycles(3);
        check_frame64("bcast_ok", LP, 0, 64'h4100, 12'd2);
        compared++;
        if (committed[LP] !== 13'd9 || drop_count !== 32'd1) begin
            mismatched++;
            $display("FAIL bcast_ok_commit: commit=%0d drops=%0d, required 9/1", committed[LP], drop_count);
        end
    endtask

    task automatic test_nonlocal;
        stalls = 0;
        wlog.delete();
        send_frame(7'd24, 12'd3, 64, 64'h6000, 1'b0);
        wait_cycles(3);
        compared++;
        if (stalls !== 0 || wlog.size() !== 0 || drop_count !== 32'd2) begin
            mismatched++;
            $display("FAIL nonlocal_drop: stalls=%0d writes=%0d drops=%0d, required 0/0/2",
                     stalls, wlog.size(), drop_count);
        end
    endtask

    task automatic test_overrun;
        wlog.delete();
        send_frame(7'd3, 12'd1, 193 * 8, 64'h3000, 1'b0);
        wait_cycles(3);
        compared++;
        if (wlog.size() !== 191 || committed[3] !== 13'd18 || drop_count !== 32'd3) begin
            mismatched++;
            $display("FAIL overrun_drop: writes=%0d commit=%0d drops=%0d, required 191/18/3",
                     wlog.size(), committed[3], drop_count);
        end
        wlog.delete();
        send_frame(7'd3, 12'd4, 64, 64'h3800, 1'b0);
        wait_cycles(3);
        check_frame64("after_overrun", 3, 18, 64'h3800, 12'd4);
        compared++;
        if (committed[3] !== 13'd27) begin
            mismatched++;
            $display("FAIL after_overrun_commit: got %0d, required 27", committed[3]);
        end
    endtask

    task automatic test_wrap;
        int e;
        e = 0;
        for (int f = 0; f < 22; f++) begin
            send_frame(7'd5, 12'd0, (f < 21) ? 1528 : 472, 64'h0, 1'b0);
            wait_cycles(2);
            e = e + ((f < 21) ? 192 : 60);
            rd_ptr[5] = 13'(e);
        end
        compared++;
        if (committed[5] !== 13'd4092) begin
            mismatched++;
            $display("FAIL wrap_fill_commit: got %0d, required 4092", committed[5]);
        end
        wlog.delete();
        send_frame(7'd5, 12'd9, 64, 64'h5000, 1'b1);
        wait_cycles(3);
        check_frame64("wrap", 5, 4092, 64'h5000, 12'd9);
        compared++;
        if (committed[5] !== 13'h1005) begin
            mismatched++;
            $display("FAIL wrap_commit: got %h, required 1005", committed[5]);
        end
    endtask

    task automatic test_reset_mid;
        bit any_nz;
        send_beat(64'h7000, 8'hFF, 1'b0, 7'd5, 12'd1);
        send_beat(64'h7001, 8'hFF, 1'b0, 7'd5, 12'd1);
        send_beat(64'h7002, 8'hFF, 1'b0, 7'd5, 12'd1);
        areset = 1'b1;
        axi_rx.tvalid = 1'b0;
        #1;
        any_nz = 1'b0;
        for (int i = 0; i < LP + 1; i++) if (committed[i] !== 13'd0) any_nz = 1'b1;
        compared++;
        if ({wr_en, wr_addr, wr_data, drop_count, axi_rx.tready, any_nz} !== '0) begin
            mismatched++;
            $display("FAIL midreset_outputs: wr_en=%b addr=%h data=%h drops=%0d tready=%b ptr_nz=%b, required all 0",
                     wr_en, wr_addr, wr_data, drop_count, axi_rx.tready, any_nz);
        end
        wait_cycles(2);
        areset = 1'b0;
        for (int i = 0; i < LP; i++) rd_ptr[i] = 13'd0;
        wait_cycles(1);
        wlog.delete();
        send_frame(7'd3, 12'd6, 64, 64'h8000, 1'b0);
        wait_cycles(3);
        check_frame64("post_reset", 3, 0, 64'h8000, 12'd6);
        compared++;
        if (committed[3] !== 13'd9) begin
            mismatched++;
            $display("FAIL post_reset_commit: got %0d, required 9", committed[3]);
        end
    endtask

    initial begin
        areset          = 1'b1;
        axi_rx.tvalid   = 1'b0;
        axi_rx.tdata    = '0;
        axi_rx.tkeep    = '0;
        axi_rx.tlast    = 1'b0;
        axi_rx.tdest    = '0;
        axi_rx.tuser    = '0;
        axi_rx.areset_n = 1'b1;
        for (int i = 0; i < LP; i++) begin
            rd_ptr[i]       = 13'd0;
            bcast_rd_ptr[i] = 13'd0;
        end
        wait_cycles(3);
        test_reset;
        test_unicast_64b;
        test_short_frame;
        test_bcast_full;
        test_nonlocal;
        test_overrun;
        test_wrap;
        test_reset_mid;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
`default_nettype wire
